uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Frames raw UART RX bytes into validated measurement commands for the acquisition
//  enable sequencer. Sits between uart_recv and the enable sequencer.
//  Presents a held command byte on cmd_data for HOLD_CYCLES, then returns it to 0x00.
//  The sequencer needs the code held stable and needs 0x00 between two commands.
// PARAMETERS
//  HOLD_CYCLES   2_300_000  cycles cmd_data stays at an accepted code (> sequencer span 2_250_500)
//  BYTE_TIMEOUT  50_000     max idle cycles between bytes of one frame (1 ms @ 50 MHz)
//  HDR_BYTE      8'hAA      frame header byte
// PORTS
//  sys_clk    in   1  system clock, 50 MHz
//  sys_rst    in   1  reset; asynchronous, active-high
//  uart_done  in   1  one-cycle strobe: uart_data valid
//  uart_data  in   8  received byte
//  cmd_data   out  8  held command to sequencer: 0xFF (1M run), 0xEF (5M run), else 0x00
//  cmd_busy   out  1  high while cmd_data != 0x00
//  frame_err  out  1  one-cycle pulse on rejected frame (bad check, bad code, timeout)
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_data=8'h00, cmd_busy=0, frame_err=0); FSM=IDLE; counters 0.
//    Reset is honoured mid-frame and mid-hold; cmd_data drops to 0x00 asynchronously.
//  Frame format: HDR_BYTE, CMD, ~CMD (bitwise complement).
//    Only CMD in {0xFF, 0xEF} is accepted.
//  Receive FSM (all bytes consumed only on uart_done):
//    IDLE    : byte==HDR_BYTE -> GET_CMD; any other byte is dropped silently.
//    GET_CMD : latch CMD -> GET_CHK.
//    GET_CHK : byte==~CMD and CMD legal -> frame_ok; otherwise frame_err pulse.
//              Goes to IDLE in either case.
//    Timeout : in GET_CMD/GET_CHK, gap counter reaches BYTE_TIMEOUT with no uart_done
//              -> frame_err pulse, IDLE.
//              Gap counter clears on every uart_done and in IDLE.
//    A HDR_BYTE arriving in GET_CMD is taken as CMD, not as a resync.
//  Output FSM:
//    OUT_IDLE : frame_ok -> cmd_data<=CMD, cmd_busy<=1, hold_cnt<=0 -> OUT_HOLD.
//    OUT_HOLD : hold_cnt increments each cycle.
//               hold_cnt==HOLD_CYCLES-1 -> cmd_data<=0x00, cmd_busy<=0 -> OUT_IDLE.
//               frame_ok during hold -> cmd_data<=0x00 for exactly one cycle (OUT_GAP).
//    OUT_GAP  : load new CMD, hold_cnt<=0 -> OUT_HOLD (applies even if CMD is the same code).
//  Latency: cmd_data takes the new code on the 1st sys_clk edge after the edge that sampled
//    the check byte's uart_done (2 edges when via OUT_GAP).
//  Simultaneous: frame_ok on the same cycle hold expires -> OUT_GAP path wins; no 0x00 glitch
//    beyond the single gap cycle.
//  frame_err never disturbs cmd_data or a hold in progress.
//  hold_cnt is 22 bits, saturating, never wraps; HOLD_CYCLES must be < 2^22.
//  Duration: cmd_data nonzero for exactly HOLD_CYCLES cycles per accepted frame unless
//    pre-empted.
//  All outputs are registered; no combinational path from uart_* to outputs.
// TESTING (sim overrides HOLD_CYCLES=1000, BYTE_TIMEOUT=100)
//  1. AA,FF,00 spaced 20 cycles -> cmd_data=FF one cycle after 3rd strobe, busy=1,
//     back to 00 after exactly 1000 cycles.
//  2. AA,EF,10 -> cmd_data=EF for 1000 cycles, frame_err stays 0.
//  3. AA,FF,01 (bad check) and AA,12,ED (illegal code) -> one frame_err pulse each,
//     cmd_data stays 00.
//  4. AA,FF then 150-cycle silence -> frame_err at gap 100, FSM IDLE;
//     following AA,EF,10 accepted normally.
//  5. During FF hold at count 400, send AA,EF,10 -> cmd_data 00 for 1 cycle, then EF
//     for 1000 cycles.
//  6. Assert sys_rst asynchronously mid-hold and mid-frame -> outputs 0 immediately;
//     stray 55,FF,00 after release ignored.

Source files
------------

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module  : uart_cmd_parser
//  Brief   : Frames UART RX bytes (HDR, CMD, ~CMD) into held measurement
//            commands for the acquisition enable sequencer.
//  Revision: 1.0  initial release
// ============================================================================
module uart_cmd_parser #(
   parameter int unsigned HOLD_CYCLES  = 2_300_000,
   parameter int unsigned BYTE_TIMEOUT = 50_000,
   parameter logic [7:0]  HDR_BYTE     = 8'hAA
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_done,
   input  logic [7:0] uart_data,
   output logic [7:0] cmd_data,
   output logic       cmd_busy,
   output logic       frame_err
);

   localparam int unsigned        c_GAP_W     = $clog2(BYTE_TIMEOUT + 1);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(BYTE_TIMEOUT - 1);
   localparam logic [21:0]        c_HOLD_LAST = 22'(HOLD_CYCLES - 1);
   localparam logic [7:0]         c_CODE_1M   = 8'hFF;
   localparam logic [7:0]         c_CODE_5M   = 8'hEF;

   localparam logic [1:0] c_RX_IDLE  = 2'd0;
   localparam logic [1:0] c_RX_CMD   = 2'd1;
   localparam logic [1:0] c_RX_CHK   = 2'd2;

   localparam logic [1:0] c_OUT_IDLE = 2'd0;
   localparam logic [1:0] c_OUT_HOLD = 2'd1;
   localparam logic [1:0] c_OUT_GAP  = 2'd2;

   logic [1:0]         r_rx_state, w_rx_next;
   logic [7:0]         r_cmd, w_cmd_nxt;
   logic [c_GAP_W-1:0] r_gap_cnt, w_gap_nxt;
   logic               r_frame_ok, w_ok_nxt;
   logic               r_frame_err, w_err_nxt;
   logic [7:0]         r_ok_code;
   logic               w_in_frame, w_timeout, w_code_legal, w_chk_match;

   logic [1:0]         r_out_state, w_out_next;
   logic [7:0]         r_cmd_data, w_cmd_data_nxt;
   logic               r_cmd_busy, w_busy_nxt;
   logic [21:0]        r_hold_cnt, w_hold_nxt;

   assign w_in_frame   = (r_rx_state != c_RX_IDLE);
   assign w_timeout    = w_in_frame && !uart_done && (r_gap_cnt == c_GAP_LAST);
   assign w_code_legal = (r_cmd == c_CODE_1M) || (r_cmd == c_CODE_5M);
   assign w_chk_match  = (uart_data == ~r_cmd);

   // ---------------- receive FSM ----------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_rx_state  <= c_RX_IDLE;
         r_cmd       <= 8'h00;
         r_gap_cnt   <= '0;
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_ok_code   <= 8'h00;
      end else begin
         r_rx_state  <= w_rx_next;
         r_cmd       <= w_cmd_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_frame_ok  <= w_ok_nxt;
         r_frame_err <= w_err_nxt;
         if (w_ok_nxt) begin
            r_ok_code <= r_cmd;
         end
      end
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         c_RX_IDLE: if (uart_done && (uart_data == HDR_BYTE)) w_rx_next = c_RX_CMD;
         c_RX_CMD : begin
            if (uart_done)      w_rx_next = c_RX_CHK;
            else if (w_timeout) w_rx_next = c_RX_IDLE;
         end
         c_RX_CHK : if (uart_done || w_timeout) w_rx_next = c_RX_IDLE;
         default  : w_rx_next = c_RX_IDLE;
      endcase
   end

   always_comb begin
      w_cmd_nxt = r_cmd;
      w_ok_nxt  = 1'b0;
      w_err_nxt = 1'b0;
      // Gap counter only runs while a frame is open and the line is quiet.
      if (!w_in_frame || uart_done || w_timeout) w_gap_nxt = '0;
      else                                       w_gap_nxt = r_gap_cnt + 1'b1;
      if ((r_rx_state == c_RX_CMD) && uart_done) w_cmd_nxt = uart_data;
      if ((r_rx_state == c_RX_CHK) && uart_done) begin
         if (w_code_legal && w_chk_match) w_ok_nxt  = 1'b1;
         else                             w_err_nxt = 1'b1;
      end
      if (w_timeout) w_err_nxt = 1'b1;
   end

   // ---------------- output FSM ----------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_out_state <= c_OUT_IDLE;
         r_cmd_data  <= 8'h00;
         r_cmd_busy  <= 1'b0;
         r_hold_cnt  <= '0;
      end else begin
         r_out_state <= w_out_next;
         r_cmd_data  <= w_cmd_data_nxt;
         r_cmd_busy  <= w_busy_nxt;
         r_hold_cnt  <= w_hold_nxt;
      end
   end

   always_comb begin
      w_out_next = r_out_state;
      case (r_out_state)
         c_OUT_IDLE: if (r_frame_ok) w_out_next = c_OUT_HOLD;
         c_OUT_HOLD: begin
            if (r_frame_ok)                      w_out_next = c_OUT_GAP;
            else if (r_hold_cnt == c_HOLD_LAST)  w_out_next = c_OUT_IDLE;
         end
         c_OUT_GAP : w_out_next = c_OUT_HOLD;
         default   : w_out_next = c_OUT_IDLE;
      endcase
   end

   always_comb begin
      w_cmd_data_nxt = r_cmd_data;
      w_busy_nxt     = r_cmd_busy;
      w_hold_nxt     = r_hold_cnt;
      case (r_out_state)
         c_OUT_IDLE: begin
            if (r_frame_ok) begin
               w_cmd_data_nxt = r_ok_code;
               w_busy_nxt     = 1'b1;
               w_hold_nxt     = '0;
            end
         end
         c_OUT_HOLD: begin
            // A new frame pre-empts expiry so the sequencer always sees one 0x00 cycle.
            if (r_frame_ok || (r_hold_cnt == c_HOLD_LAST)) begin
               w_cmd_data_nxt = 8'h00;
               w_busy_nxt     = 1'b0;
            end else if (r_hold_cnt != '1) begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         c_OUT_GAP: begin
            w_cmd_data_nxt = r_ok_code;
            w_busy_nxt     = 1'b1;
            w_hold_nxt     = '0;
         end
         default: begin
            w_cmd_data_nxt = 8'h00;
            w_busy_nxt     = 1'b0;
            w_hold_nxt     = '0;
         end
      endcase
   end

   assign cmd_data  = r_cmd_data;
   assign cmd_busy  = r_cmd_busy;
   assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_cmd_parser
//  Brief   : Self-checking bench for uart_cmd_parser against a frame-level model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_uart_cmd_parser;

   localparam int         HOLD = 1000;
   localparam int         TMO  = 100;
   localparam logic [7:0] HDR  = 8'hAA;

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic       done = 1'b0;
   logic [7:0] data = 8'h00;
   logic [7:0] cmd_data;
   logic       cmd_busy;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   uart_cmd_parser #(
      .HOLD_CYCLES (HOLD),
      .BYTE_TIMEOUT(TMO),
      .HDR_BYTE    (HDR)
   ) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .uart_done(done),
      .uart_data(data),
      .cmd_data (cmd_data),
      .cmd_busy (cmd_busy),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Reference model: collected frame bytes, idle time, and remaining hold cycles.
   logic [7:0] frm [$];
   int         m_since;
   int         m_left;
   logic [7:0] m_cmd;
   logic       m_err;
   logic       m_ok;
   logic [7:0] m_ok_code;
   logic       m_gap;
   logic [7:0] m_gap_code;
   logic       m_busy;
   assign m_busy = (m_cmd != 8'h00);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         frm.delete();
         m_since = 0; m_left = 0; m_cmd = 8'h00; m_err = 1'b0;
         m_ok = 1'b0; m_ok_code = 8'h00; m_gap = 1'b0; m_gap_code = 8'h00;
      end else begin
         if (m_gap) begin
            m_cmd = m_gap_code; m_left = HOLD; m_gap = 1'b0;
         end else if (m_ok && m_left > 0) begin
            m_cmd = 8'h00; m_left = 0; m_gap = 1'b1; m_gap_code = m_ok_code;
         end else if (m_ok) begin
            m_cmd = m_ok_code; m_left = HOLD;
         end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_cmd = 8'h00;
         end
         m_ok = 1'b0; m_err = 1'b0;
         if (done) begin
            m_since = 0;
            if (frm.size() == 0) begin
               if (data == HDR) frm.push_back(data);
            end else if (frm.size() == 1) begin
               frm.push_back(data);
            end else begin
               if (data == ~frm[1] && (frm[1] == 8'hFF || frm[1] == 8'hEF)) begin
                  m_ok = 1'b1; m_ok_code = frm[1];
               end else begin
                  m_err = 1'b1;
               end
               frm.delete();
            end
         end else if (frm.size() != 0) begin
            m_since = m_since + 1;
            if (m_since == TMO) begin
               m_err = 1'b1; frm.delete(); m_since = 0;
            end
         end
      end
   end

   // Stimulus queue: one entry per clock cycle.
   logic       q_done [$];
   logic [7:0] q_data [$];

   task automatic put_byte(input logic [7:0] b, input int gap);
      q_done.push_back(1'b1); q_data.push_back(b);
      for (int k = 0; k < gap; k++) begin
         q_done.push_back(1'b0); q_data.push_back(8'($urandom));
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_data !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h expected 00", cmd_data); end
      checks++;
      if (cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", cmd_busy); end
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", frame_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_good_frames();
      logic [7:0] code [3];
      int chk_at [3];
      int nz, errs, first_nz;
      q_done.delete(); q_data.delete();
      code[0] = 8'hFF; code[1] = 8'hEF;
      code[2] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hEF;
      for (int f = 0; f < 3; f++) begin
         int g;
         g = (f == 0) ? 19 : int'($urandom_range(0, 30));
         put_byte(HDR, g); put_byte(code[f], g);
         chk_at[f] = q_done.size();
         put_byte(~code[f], HOLD + 30);
      end
      nz = 0; errs = 0; first_nz = -1;
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL good_frames tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
         if (cmd_data !== 8'h00) begin nz++; if (first_nz < 0) first_nz = i; end
         if (frame_err === 1'b1) errs++;
         for (int f = 0; f < 3; f++) begin
            if (i == chk_at[f] + HOLD + 1) begin
               checks++;
               if (cmd_data !== 8'h00) begin errors++; $display("FAIL good_release frame %0d got %h expected 00", f, cmd_data); end
            end
         end
      end
      done = 1'b0;
      checks++;
      if (first_nz !== chk_at[0] + 1) begin errors++; $display("FAIL good_latency got tick %0d expected %0d", first_nz, chk_at[0] + 1); end
      checks++;
      if (nz !== 3 * HOLD) begin errors++; $display("FAIL good_duration got %0d expected %0d", nz, 3 * HOLD); end
      checks++;
      if (errs !== 0) begin errors++; $display("FAIL good_no_err got %0d expected 0", errs); end
   endtask

   task automatic test_bad_frames();
      logic [7:0] c;
      int nz, errs, n_bad;
      q_done.delete(); q_data.delete();
      put_byte(HDR, 5); put_byte(8'hFF, 5); put_byte(8'h01, 20);
      put_byte(HDR, 5); put_byte(8'h12, 5); put_byte(8'hED, 20);
      n_bad = 2;
      for (int n = 0; n < 6; n++) begin
         do c = 8'($urandom); while (c == HDR);
         put_byte(c, int'($urandom_range(0, 8)));
         do c = 8'($urandom); while (c == 8'hFF || c == 8'hEF);
         put_byte(HDR, int'($urandom_range(0, 8))); put_byte(c, int'($urandom_range(0, 8)));
         put_byte(~c, int'($urandom_range(1, 8)));
         n_bad++;
      end
      nz = 0; errs = 0;
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL bad_frames tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
         if (cmd_data !== 8'h00) nz++;
         if (frame_err === 1'b1) errs++;
      end
      done = 1'b0;
      checks++;
      if (errs !== n_bad) begin errors++; $display("FAIL bad_err_count got %0d expected %0d", errs, n_bad); end
      checks++;
      if (nz !== 0) begin errors++; $display("FAIL bad_cmd_quiet got %0d nonzero cycles expected 0", nz); end
   endtask

   task automatic test_timeout();
      int idx_ff, idx_aa, nz, errs, err_t0, err_t1;
      q_done.delete(); q_data.delete();
      put_byte(HDR, 10);
      idx_ff = q_done.size();
      put_byte(8'hFF, 150);
      idx_aa = q_done.size();
      put_byte(HDR, 150);
      put_byte(HDR, 5); put_byte(8'hEF, 5); put_byte(8'h10, HOLD + 20);
      nz = 0; errs = 0; err_t0 = -1; err_t1 = -1;
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL timeout tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
         if (cmd_data === 8'hEF) nz++;
         if (frame_err === 1'b1) begin
            errs++;
            if (err_t0 < 0) err_t0 = i; else err_t1 = i;
         end
      end
      done = 1'b0;
      checks++;
      if (err_t0 !== idx_ff + TMO) begin errors++; $display("FAIL timeout_chk_gap got tick %0d expected %0d", err_t0, idx_ff + TMO); end
      checks++;
      if (err_t1 !== idx_aa + TMO) begin errors++; $display("FAIL timeout_cmd_gap got tick %0d expected %0d", err_t1, idx_aa + TMO); end
      checks++;
      if (errs !== 2) begin errors++; $display("FAIL timeout_err_count got %0d expected 2", errs); end
      checks++;
      if (nz !== HOLD) begin errors++; $display("FAIL timeout_recovery got %0d EF cycles expected %0d", nz, HOLD); end
   endtask

   task automatic test_preempt();
      int c1, n_ff, n_ef;
      q_done.delete(); q_data.delete();
      put_byte(HDR, 4); put_byte(8'hFF, 4);
      c1 = q_done.size();
      put_byte(8'h00, 390);
      put_byte(HDR, 4); put_byte(8'hEF, 4); put_byte(8'h10, 990);
      put_byte(HDR, 4); put_byte(8'hEF, 4); put_byte(8'h10, HOLD + 20);
      n_ff = 0; n_ef = 0;
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL preempt tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
         if (cmd_data === 8'hFF) n_ff++;
         if (cmd_data === 8'hEF) n_ef++;
         if (i == c1 + 402 || i == c1 + 1403) begin
            checks++;
            if (cmd_data !== 8'h00) begin errors++; $display("FAIL preempt_gap tick %0d got %h expected 00", i, cmd_data); end
         end
         if (i == c1 + 403 || i == c1 + 1402 || i == c1 + 1404) begin
            checks++;
            if (cmd_data !== 8'hEF) begin errors++; $display("FAIL preempt_load tick %0d got %h expected EF", i, cmd_data); end
         end
      end
      done = 1'b0;
      checks++;
      if (n_ff !== 401) begin errors++; $display("FAIL preempt_ff_span got %0d expected 401", n_ff); end
      checks++;
      if (n_ef !== 2 * HOLD) begin errors++; $display("FAIL preempt_ef_span got %0d expected %0d", n_ef, 2 * HOLD); end
   endtask

   task automatic test_random();
      logic [7:0] c;
      q_done.delete(); q_data.delete();
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 5))
            0: begin
               c = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hEF;
               put_byte(HDR, int'($urandom_range(0, 20))); put_byte(c, int'($urandom_range(0, 20)));
               put_byte(~c, ($urandom_range(0, 3) == 0) ? HOLD + 20 : int'($urandom_range(0, 60)));
            end
            1: begin
               c = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hEF;
               put_byte(HDR, int'($urandom_range(0, 20))); put_byte(c, int'($urandom_range(0, 20)));
               put_byte(~c ^ (8'h01 << $urandom_range(0, 7)), int'($urandom_range(0, 30)));
            end
            2: begin
               do c = 8'($urandom); while (c == 8'hFF || c == 8'hEF);
               put_byte(HDR, int'($urandom_range(0, 20))); put_byte(c, int'($urandom_range(0, 20)));
               put_byte(~c, int'($urandom_range(0, 30)));
            end
            3: begin
               do c = 8'($urandom); while (c == HDR);
               put_byte(c, int'($urandom_range(0, 10)));
            end
            4: put_byte(HDR, int'($urandom_range(0, TMO + 30)));
            default: begin
               put_byte(HDR, 1); put_byte(HDR, 1); put_byte(8'h55, 5);
            end
         endcase
      end
      put_byte(8'h00, HOLD + 20);
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL random tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_async_reset();
      int nz, errs;
      q_done.delete(); q_data.delete();
      put_byte(HDR, 3); put_byte(8'hFF, 3); put_byte(8'h00, 300);
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL async_hold tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
      end
      done = 1'b0;
      checks++;
      if (cmd_data !== 8'hFF) begin errors++; $display("FAIL async_pre_hold got %h expected FF", cmd_data); end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({cmd_data, cmd_busy, frame_err} !== 10'h000) begin
         errors++; $display("FAIL async_mid_hold got cmd=%h busy=%b err=%b expected 00/0/0", cmd_data, cmd_busy, frame_err);
      end
      @(negedge clk);
      rst = 1'b0;
      q_done.delete(); q_data.delete();
      put_byte(HDR, 3); put_byte(8'hEF, 3);
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
      end
      done = 1'b0;
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({cmd_data, cmd_busy, frame_err} !== 10'h000) begin
         errors++; $display("FAIL async_mid_frame got cmd=%h busy=%b err=%b expected 00/0/0", cmd_data, cmd_busy, frame_err);
      end
      @(negedge clk);
      rst = 1'b0;
      q_done.delete(); q_data.delete();
      put_byte(8'h10, 5); put_byte(8'h55, 4); put_byte(8'hFF, 4); put_byte(8'h00, 200);
      put_byte(HDR, 2); put_byte(8'hEF, 2); put_byte(8'h10, HOLD + 10);
      nz = 0; errs = 0;
      for (int i = 0; i < int'(q_done.size()); i++) begin
         done = q_done[i]; data = q_data[i];
         @(negedge clk);
         checks++;
         if ({cmd_data, cmd_busy, frame_err} !== {m_cmd, m_busy, m_err}) begin
            errors++;
            $display("FAIL async_after tick %0d: got cmd=%h busy=%b err=%b, expected cmd=%h busy=%b err=%b",
                     i, cmd_data, cmd_busy, frame_err, m_cmd, m_busy, m_err);
         end
         if (cmd_data !== 8'h00) nz++;
         if (frame_err === 1'b1) errs++;
      end
      done = 1'b0;
      checks++;
      if (errs !== 0) begin errors++; $display("FAIL async_stray_err got %0d expected 0", errs); end
      checks++;
      if (nz !== HOLD) begin errors++; $display("FAIL async_stray_cmd got %0d nonzero cycles expected %0d", nz, HOLD); end
   endtask

   initial begin
      test_reset();
      test_good_frames();
      test_bad_frames();
      test_timeout();
      test_preempt();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
